// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the single-port memory and
// the riscv_mem_arbiter; the arbiter connects through the slave modport.
interface riscv_mem_arbiter_if;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        dm_req;
   logic        dm_we;
   logic [63:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   // Requesters plus memory model side.
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   // Arbiter side.
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter for one single-port memory, one transaction in flight.
// Optional fetch starvation guard: define RISCV_ARB_STARVE_GUARD_EN.
module riscv_mem_arbiter #(
   parameter int unsigned MEM_LAT      = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   riscv_mem_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [63:0] WORD_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   if ((MEM_LAT < 1) || (MEM_LAT > 8)) begin : g_bad_mem_lat
      $error("riscv_mem_arbiter: MEM_LAT must be in 1..8");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
      $error("riscv_mem_arbiter: STARVE_LIMIT must be at least 1");
   end

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               win_dm_q, win_dm_d;
   logic               if_gnt_q, if_gnt_d;
   logic               dm_gnt_q, dm_gnt_d;
   logic               if_rvalid_q, if_rvalid_d;
   logic               dm_rvalid_q, dm_rvalid_d;
   logic [31:0]        if_rdata_q, if_rdata_d;
   logic [31:0]        dm_rdata_q, dm_rdata_d;
   logic               mem_en_q, mem_en_d;
   logic               mem_we_q, mem_we_d;
   logic [63:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic               busy_q, busy_d;

   logic               last_s;
   logic               arb_s;
   logic               force_if_s;
   logic               new_dm_s;
   logic               new_if_s;

   // Arbitration happens in IDLE, on the final WAIT edge (so the next grant
   // lands in the RESP cycle) and in a RESP cycle that carries no new grant.
   always_comb begin
      last_s = (cnt_q == CNT_W'(MEM_LAT));
      arb_s  = 1'b0;
      case (state_q)
         IDLE:    arb_s = 1'b1;
         WAIT:    arb_s = last_s;
         RESP:    arb_s = ~(if_gnt_q | dm_gnt_q);
         default: arb_s = 1'b0;
      endcase
      new_dm_s = arb_s & bus.dm_req & ~force_if_s;
      new_if_s = arb_s & bus.if_req & ~new_dm_s;
   end

`ifdef RISCV_ARB_STARVE_GUARD_EN
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
   logic [STV_W-1:0] starve_q, starve_d;

   assign force_if_s = bus.if_req & (starve_q == STV_W'(STARVE_LIMIT));

   // Count data grants that overtook a waiting fetch.
   always_comb begin
      starve_d = starve_q;
      if (arb_s) begin
         if (new_if_s || !bus.if_req) begin
            starve_d = {STV_W{1'b0}};
         end else if (new_dm_s) begin
            starve_d = starve_q + STV_W'(1);
         end else begin
            starve_d = starve_q;
         end
      end else begin
         starve_d = starve_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         starve_q <= {STV_W{1'b0}};
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign force_if_s = 1'b0;
`endif

   // Next state, latency counter, response capture and grant outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      win_dm_d    = win_dm_q;
      if_gnt_d    = 1'b0;
      dm_gnt_d    = 1'b0;
      mem_en_d    = 1'b0;
      if_rvalid_d = 1'b0;
      dm_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = (new_dm_s | new_if_s) ? WAIT : IDLE;
         end
         WAIT: begin
            if (last_s) begin
               state_d = RESP;
               cnt_d   = {CNT_W{1'b0}};
               if (win_dm_q) begin
                  dm_rvalid_d = 1'b1;
                  dm_rdata_d  = mem_we_q ? 32'h0000_0000 : bus.mem_rdata;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            // A grant issued in this cycle already counts as its first WAIT cycle.
            if (if_gnt_q || dm_gnt_q) begin
               state_d = WAIT;
               cnt_d   = cnt_q + CNT_W'(1);
            end else if (new_dm_s || new_if_s) begin
               state_d = WAIT;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase

      if (new_dm_s) begin
         dm_gnt_d    = 1'b1;
         mem_en_d    = 1'b1;
         mem_we_d    = bus.dm_we;
         mem_addr_d  = bus.dm_addr & WORD_MASK;
         mem_wdata_d = bus.dm_wdata;
         win_dm_d    = 1'b1;
      end else if (new_if_s) begin
         if_gnt_d    = 1'b1;
         mem_en_d    = 1'b1;
         mem_we_d    = 1'b0;
         mem_addr_d  = bus.if_addr & WORD_MASK;
         win_dm_d    = 1'b0;
      end else begin
         win_dm_d    = win_dm_q;
      end

      busy_d = new_dm_s | new_if_s | (state_d == WAIT);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         win_dm_q    <= 1'b0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= 32'h0000_0000;
         dm_rdata_q  <= 32'h0000_0000;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 64'h0000_0000_0000_0000;
         mem_wdata_q <= 32'h0000_0000;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         win_dm_q    <= win_dm_d;
         if_gnt_q    <= if_gnt_d;
         dm_gnt_q    <= dm_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.dm_gnt    = dm_gnt_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.dm_rvalid = dm_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: main instance at MEM_LAT=2, plus
// MEM_LAT=1 and MEM_LAT=8 instances for back-to-back fetch spacing.
module tb_riscv_mem_arbiter;
   logic        clock;
   logic        rst_n;
   int          errors = 0;
   int          checks = 0;

   logic [31:0] mem_words [16];
   logic [31:0] pipe2 [8];
   logic [31:0] pipe1 [8];
   logic [31:0] pipe8 [8];

   logic        bb_req;
   logic [63:0] bb_addr;
   int          bb_sel;
   logic        obs_gnt;
   logic        obs_rvalid;
   logic [31:0] obs_rdata;

`ifdef RISCV_ARB_STARVE_GUARD_EN
   localparam logic [9:0] EXP_IF_PATTERN = 10'b10_0001_0000;
`else
   localparam logic [9:0] EXP_IF_PATTERN = 10'b00_0000_0000;
`endif

   riscv_mem_arbiter_if bus2 ();
   riscv_mem_arbiter_if bus1 ();
   riscv_mem_arbiter_if bus8 ();

   riscv_mem_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(4)) u_dut2 (.clock(clock), .reset_n(rst_n), .bus(bus2));
   riscv_mem_arbiter #(.MEM_LAT(1), .STARVE_LIMIT(4)) u_dut1 (.clock(clock), .reset_n(rst_n), .bus(bus1));
   riscv_mem_arbiter #(.MEM_LAT(8), .STARVE_LIMIT(4)) u_dut8 (.clock(clock), .reset_n(rst_n), .bus(bus8));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Memory model: word appears MEM_LAT cycles after the mem_en cycle, and
   // only in that one cycle (garbage otherwise) so capture timing is exact.
   always @(posedge clock) begin
      pipe2[0] <= bus2.mem_en ? mem_words[bus2.mem_addr[5:2]] : 32'hDEAD_BEEF;
      pipe1[0] <= bus1.mem_en ? mem_words[bus1.mem_addr[5:2]] : 32'hDEAD_BEEF;
      pipe8[0] <= bus8.mem_en ? mem_words[bus8.mem_addr[5:2]] : 32'hDEAD_BEEF;
      for (int i = 1; i < 8; i++) begin
         pipe2[i] <= pipe2[i-1];
         pipe1[i] <= pipe1[i-1];
         pipe8[i] <= pipe8[i-1];
      end
   end
   assign bus2.mem_rdata = pipe2[1];
   assign bus1.mem_rdata = pipe1[0];
   assign bus8.mem_rdata = pipe8[7];

   assign bus1.if_req   = bb_req & (bb_sel == 0);
   assign bus8.if_req   = bb_req & (bb_sel == 1);
   assign bus1.if_addr  = bb_addr;
   assign bus8.if_addr  = bb_addr;
   assign bus1.dm_req   = 1'b0;
   assign bus8.dm_req   = 1'b0;
   assign bus1.dm_we    = 1'b0;
   assign bus8.dm_we    = 1'b0;
   assign bus1.dm_addr  = 64'h0;
   assign bus8.dm_addr  = 64'h0;
   assign bus1.dm_wdata = 32'h0;
   assign bus8.dm_wdata = 32'h0;

   always_comb begin
      obs_gnt    = (bb_sel == 0) ? bus1.if_gnt    : bus8.if_gnt;
      obs_rvalid = (bb_sel == 0) ? bus1.if_rvalid : bus8.if_rvalid;
      obs_rdata  = (bb_sel == 0) ? bus1.if_rdata  : bus8.if_rdata;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      int n;
      n = 0;
      while ((bus2.busy || bus2.dm_rvalid || bus2.if_rvalid) && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (bus2.busy !== 1'b0) begin
         errors++;
         $display("FAIL settle_timeout: busy=%b required 0", bus2.busy);
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus2.if_req = 1'b0; bus2.if_addr = 64'h0;
      bus2.dm_req = 1'b0; bus2.dm_we = 1'b0; bus2.dm_addr = 64'h0; bus2.dm_wdata = 32'h0;
      bb_req = 1'b0; bb_addr = 64'h0; bb_sel = 0;
      repeat (3) tick();
      checks++;
      if ({bus2.if_gnt, bus2.dm_gnt, bus2.if_rvalid, bus2.dm_rvalid, bus2.mem_en, bus2.mem_we, bus2.busy} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0000000",
                  {bus2.if_gnt, bus2.dm_gnt, bus2.if_rvalid, bus2.dm_rvalid, bus2.mem_en, bus2.mem_we, bus2.busy});
      end
      checks++;
      if ({bus2.if_rdata, bus2.dm_rdata, bus2.mem_wdata} !== 96'h0) begin
         errors++;
         $display("FAIL reset_data: got %h required 0", {bus2.if_rdata, bus2.dm_rdata, bus2.mem_wdata});
      end
      checks++;
      if (bus2.mem_addr !== 64'h0) begin
         errors++;
         $display("FAIL reset_addr: got %h required 0", bus2.mem_addr);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_load();
      bus2.dm_req = 1'b1; bus2.dm_we = 1'b0; bus2.dm_addr = 64'h10;
      tick();
      checks++;
      if ({bus2.dm_gnt, bus2.if_gnt, bus2.mem_en, bus2.mem_we, bus2.busy} !== 5'b10101) begin
         errors++;
         $display("FAIL load_gnt: gnt/ifgnt/en/we/busy=%b required 10101",
                  {bus2.dm_gnt, bus2.if_gnt, bus2.mem_en, bus2.mem_we, bus2.busy});
      end
      checks++;
      if (bus2.mem_addr !== 64'h10) begin
         errors++;
         $display("FAIL load_addr: got %h required 10", bus2.mem_addr);
      end
      bus2.dm_req = 1'b0;
      tick();
      checks++;
      if ({bus2.dm_gnt, bus2.mem_en, bus2.busy, bus2.dm_rvalid} !== 4'b0010) begin
         errors++;
         $display("FAIL load_wait: gnt/en/busy/rvalid=%b required 0010",
                  {bus2.dm_gnt, bus2.mem_en, bus2.busy, bus2.dm_rvalid});
      end
      tick();
      checks++;
      if (bus2.dm_rvalid !== 1'b0 || bus2.busy !== 1'b1) begin
         errors++;
         $display("FAIL load_early: rvalid=%b busy=%b required 0 1", bus2.dm_rvalid, bus2.busy);
      end
      tick();
      checks++;
      if (bus2.dm_rvalid !== 1'b1 || bus2.busy !== 1'b0) begin
         errors++;
         $display("FAIL load_rvalid: rvalid=%b busy=%b required 1 0", bus2.dm_rvalid, bus2.busy);
      end
      checks++;
      if (bus2.dm_rdata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL load_rdata: got %h required 12345678", bus2.dm_rdata);
      end
      tick();
      checks++;
      if (bus2.dm_rvalid !== 1'b0 || bus2.dm_rdata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL load_hold: rvalid=%b rdata=%h required 0 12345678", bus2.dm_rvalid, bus2.dm_rdata);
      end
   endtask

   task automatic test_priority();
      settle();
      bus2.dm_req = 1'b1; bus2.dm_we = 1'b0; bus2.dm_addr = 64'h4;
      bus2.if_req = 1'b1; bus2.if_addr = 64'h8;
      tick();
      checks++;
      if (bus2.dm_gnt !== 1'b1 || bus2.if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL prio_first: dm_gnt=%b if_gnt=%b required 1 0", bus2.dm_gnt, bus2.if_gnt);
      end
      bus2.dm_req = 1'b0;
      tick();
      tick();
      checks++;
      if (bus2.if_gnt !== 1'b0) begin
         errors++;
         $display("FAIL prio_early_if: if_gnt=%b required 0", bus2.if_gnt);
      end
      tick();
      checks++;
      if (bus2.if_gnt !== 1'b1 || bus2.dm_rvalid !== 1'b1 || bus2.mem_addr !== 64'h8) begin
         errors++;
         $display("FAIL prio_if_gnt: if_gnt=%b dm_rvalid=%b addr=%h required 1 1 8",
                  bus2.if_gnt, bus2.dm_rvalid, bus2.mem_addr);
      end
      checks++;
      if (bus2.dm_rdata !== 32'hA000_0001) begin
         errors++;
         $display("FAIL prio_dm_rdata: got %h required a0000001", bus2.dm_rdata);
      end
      bus2.if_req = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus2.if_rvalid !== 1'b1 || bus2.if_rdata !== 32'hA000_0002) begin
         errors++;
         $display("FAIL prio_if_rdata: rvalid=%b rdata=%h required 1 a0000002", bus2.if_rvalid, bus2.if_rdata);
      end
   endtask

   task automatic test_store();
      settle();
      bus2.dm_req = 1'b1; bus2.dm_we = 1'b1; bus2.dm_addr = 64'h23; bus2.dm_wdata = 32'hCAFE_F00D;
      tick();
      checks++;
      if ({bus2.dm_gnt, bus2.mem_en, bus2.mem_we} !== 3'b111 || bus2.mem_addr !== 64'h20) begin
         errors++;
         $display("FAIL store_gnt: gnt/en/we=%b addr=%h required 111 20",
                  {bus2.dm_gnt, bus2.mem_en, bus2.mem_we}, bus2.mem_addr);
      end
      checks++;
      if (bus2.mem_wdata !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL store_wdata: got %h required cafef00d", bus2.mem_wdata);
      end
      bus2.dm_req = 1'b0; bus2.dm_we = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus2.dm_rvalid !== 1'b1 || bus2.dm_rdata !== 32'h0) begin
         errors++;
         $display("FAIL store_resp: rvalid=%b rdata=%h required 1 0", bus2.dm_rvalid, bus2.dm_rdata);
      end
   endtask

   task automatic test_starvation();
      logic [9:0] pat;
      int ng;
      int both;
      settle();
      pat = 10'b0; ng = 0; both = 0;
      bus2.dm_req = 1'b1; bus2.dm_we = 1'b0; bus2.dm_addr = 64'h4;
      bus2.if_req = 1'b1; bus2.if_addr = 64'h8;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (bus2.dm_gnt && bus2.if_gnt) both++;
         if (bus2.dm_gnt || bus2.if_gnt) begin
            if (ng < 10) pat[ng] = bus2.if_gnt;
            ng++;
         end
      end
      bus2.dm_req = 1'b0; bus2.if_req = 1'b0;
      checks++;
      if (ng !== 10) begin
         errors++;
         $display("FAIL starve_count: grants=%0d required 10", ng);
      end
      checks++;
      if (pat !== EXP_IF_PATTERN) begin
         errors++;
         $display("FAIL starve_pattern: fetch grant slots=%b required %b", pat, EXP_IF_PATTERN);
      end
      checks++;
      if (both !== 0) begin
         errors++;
         $display("FAIL starve_exclusive: dual grants=%0d required 0", both);
      end
   endtask

   task automatic test_reset_mid();
      int dm_rv;
      settle();
      dm_rv = 0;
      bus2.dm_req = 1'b1; bus2.dm_we = 1'b0; bus2.dm_addr = 64'h10;
      tick();
      checks++;
      if (bus2.dm_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_gnt: dm_gnt=%b required 1", bus2.dm_gnt);
      end
      bus2.dm_req = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus2.busy, bus2.mem_en, bus2.mem_we, bus2.dm_rvalid, bus2.if_rvalid, bus2.mem_addr,
           bus2.mem_wdata, bus2.if_rdata, bus2.dm_rdata} !== 165'h0) begin
         errors++;
         $display("FAIL rstmid_clear: addr=%h wdata=%h if_rdata=%h busy=%b required all 0",
                  bus2.mem_addr, bus2.mem_wdata, bus2.if_rdata, bus2.busy);
      end
      #2 rst_n = 1'b1;
      bus2.if_req = 1'b1; bus2.if_addr = 64'hC;
      tick();
      checks++;
      if (bus2.if_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_regrant: if_gnt=%b required 1", bus2.if_gnt);
      end
      bus2.if_req = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (bus2.dm_rvalid) dm_rv++;
         if (c == 3) begin
            checks++;
            if (bus2.if_rvalid !== 1'b1 || bus2.if_rdata !== 32'hA000_0003) begin
               errors++;
               $display("FAIL rstmid_fetch: rvalid=%b rdata=%h required 1 a0000003", bus2.if_rvalid, bus2.if_rdata);
            end
         end
      end
      checks++;
      if (dm_rv !== 0) begin
         errors++;
         $display("FAIL rstmid_ghost: dm_rvalid pulses=%0d required 0", dm_rv);
      end
   endtask

   task automatic test_back_to_back(input int sel, input int spacing);
      int ng;
      int nr;
      int first;
      int last;
      bb_sel = sel;
      ng = 0; nr = 0; first = 0; last = 0;
      bb_addr = 64'h14;
      bb_req = 1'b1;
      for (int cyc = 1; cyc <= 60 && nr < 3; cyc++) begin
         tick();
         if (obs_gnt) begin
            if (ng == 0) begin
               first = cyc;
            end else begin
               checks++;
               if (cyc - last !== spacing) begin
                  errors++;
                  $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d", sel, cyc - last, spacing);
               end
            end
            last = cyc;
            ng++;
            if (ng == 3) bb_req = 1'b0;
            else bb_addr = 64'h14 + 64'(4 * ng);
         end
         if (obs_rvalid) begin
            if (nr == 0) begin
               checks++;
               if (cyc - first !== spacing) begin
                  errors++;
                  $display("FAIL b2b_latency[%0d]: got %0d cycles required %0d", sel, cyc - first, spacing);
               end
            end
            checks++;
            if (obs_rdata !== 32'hA000_0005 + 32'(nr)) begin
               errors++;
               $display("FAIL b2b_rdata[%0d]: got %h required %h", sel, obs_rdata, 32'hA000_0005 + 32'(nr));
            end
            nr++;
         end
      end
      bb_req = 1'b0;
      checks++;
      if (ng !== 3 || nr !== 3) begin
         errors++;
         $display("FAIL b2b_timeout[%0d]: grants=%0d responses=%0d required 3 3", sel, ng, nr);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem_words[i] = 32'hA000_0000 + 32'(i);
      mem_words[4] = 32'h1234_5678;
      test_reset();
      test_single_load();
      test_priority();
      test_store();
      test_starvation();
      test_reset_mid();
      test_back_to_back(0, 2);
      test_back_to_back(1, 9);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..8.
REQ-002 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while if_req is pending (guard builds only).
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch request; held until if_gnt.
REQ-006 if_addr  in  64  fetch byte address.
REQ-007 if_gnt  out  1  one-cycle pulse: fetch accepted.
REQ-008 if_rvalid  out  1  one-cycle pulse: if_rdata valid.
REQ-009 if_rdata  out  32  fetched instruction word.
REQ-010 dm_req  in  1  data request; held until dm_gnt.
REQ-011 dm_we  in  1  1 = store, 0 = load.
REQ-012 dm_addr  in  64  data byte address.
REQ-013 dm_wdata  in  32  store data.
REQ-014 dm_gnt  out  1  one-cycle pulse: data request accepted.
REQ-015 dm_rvalid  out  1  one-cycle pulse: load data valid, or store completed.
REQ-016 dm_rdata  out  32  load data; 0 on store completion.
REQ-017 mem_en, mem_we  out  1 each  single-port memory strobe and write enable.
REQ-018 mem_addr  out  64  byte address, bits [1:0] forced to 0.
REQ-019 mem_wdata  out  32  write data.  mem_rdata  in  32  read data.
REQ-020 busy  out  1  high while a transaction is outstanding.

Function
REQ-021 FSM states: IDLE, WAIT, RESP. Only one transaction is outstanding at a time.
REQ-022 IDLE: request lines are sampled at the clock edge. If any request is pending, the arbiter enters WAIT and, for the following cycle only, asserts the winner's gnt, mem_en, and registered mem_we/mem_addr/mem_wdata. mem_we equals dm_we for a data grant and 0 for a fetch grant.
REQ-023 WAIT: a counter advances once per cycle. When it reaches MEM_LAT, mem_rdata is captured into the winner's rdata at that edge and the FSM enters RESP.
REQ-024 RESP: the winner's rvalid is high for exactly one cycle. Request lines are arbitrated in this cycle exactly as in IDLE, so grant-to-grant spacing is MEM_LAT+1 cycles.
REQ-025 Latency: if_rvalid and dm_rvalid assert MEM_LAT+1 cycles after the corresponding gnt cycle.
REQ-026 Priority: dm_req wins over if_req.
REQ-027 Requests are sampled only in IDLE and RESP. A requester deasserts req in the cycle after gnt unless it is presenting a new request.
REQ-028 busy is high from the gnt cycle through the last WAIT cycle.
REQ-029 Outputs other than the one-cycle pulses hold their last values; rdata holds until the next capture.
REQ-030 mem_en, if_gnt, and dm_gnt are never high together with a second grant.

Reset
REQ-031 When reset_n is low, the FSM enters IDLE and every output is 0: gnt, rvalid, rdata, mem_*, busy. The WAIT counter and the starvation counter are also 0.
REQ-032 Reset asserted mid-transaction drops the in-flight response; no rvalid is issued after reset is released.
REQ-033 The first grant can occur at the first posedge after reset_n rises.

Configuration
REQ-034 Macro RISCV_ARB_STARVE_GUARD_EN: when defined, a counter increments on each data grant made while if_req is high. The counter clears on a fetch grant or when if_req is low at arbitration.
REQ-035 When the counter equals STARVE_LIMIT, the next arbitration grants fetch even if dm_req is high.
REQ-036 When the macro is undefined, the counter is not built and data priority is strict.

Verification
REQ-037 Single load, MEM_LAT=2: dm_req=1, dm_addr=0x10, memory word 0x12345678. Expect dm_gnt at cycle 1, mem_addr=0x10, dm_rvalid at cycle 4 with dm_rdata=0x12345678.
REQ-038 Simultaneous if_req and dm_req, strict build: expect dm_gnt first, then if_gnt exactly 3 cycles later, concurrent with dm_rvalid.
REQ-039 Store: dm_we=1, dm_addr=0x23, dm_wdata=0xCAFEF00D. Expect mem_we=1, mem_addr=0x20, mem_wdata=0xCAFEF00D, then dm_rvalid with dm_rdata=0.
REQ-040 Guard build, STARVE_LIMIT=4, both requests held continuously: expect 4 dm_gnt pulses, then 1 if_gnt, repeating. Strict build: no if_gnt occurs.
REQ-041 reset_n pulsed low in the WAIT cycle after gnt: all outputs go to 0 immediately, no rvalid follows, and a new request is granted at the first edge after release.
REQ-042 Back-to-back fetches with MEM_LAT=1 and MEM_LAT=8: grant spacing measures 2 and 9 cycles, and the rdata sequence matches memory contents.
